// File: rtl/ppu_loader.sv
// ppu_loader: bus master that streams bytes into or out of PPU VRAM by issuing
// the same STATUS / ADDR / DATA register sequence a CPU would.
module ppu_loader #(
  parameter logic [15:0] REG_BASE = 16'h2000
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [13:0] cmd_addr,
  input  logic [10:0] cmd_len,
  input  logic        cmd_read,
  output logic        busy,
  output logic        done,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_en,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_wr,
  input  logic [7:0]  bus_din,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [15:0] STATUS_ADDR = REG_BASE + 16'd2;
  localparam logic [15:0] VADDR_ADDR  = REG_BASE + 16'd6;
  localparam logic [15:0] DATA_ADDR   = REG_BASE + 16'd7;
  localparam logic [10:0] MAX_LEN     = 11'd1024;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_REQ     = 4'd1,
    S_LATCH   = 4'd2,
    S_ADDR_HI = 4'd3,
    S_ADDR_LO = 4'd4,
    S_WDATA   = 4'd5,
    S_RISSUE  = 4'd6,
    S_RCAPT   = 4'd7,
    S_RHOLD   = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [13:0] r_addr;
  logic [10:0] r_rem;
  logic        r_read;
  logic [7:0]  r_out_data;
  logic        r_out_valid;

  logic [10:0] w_len;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_acc_en;
  logic        w_acc_rd;
  logic [15:0] w_acc_addr;
  logic [7:0]  w_acc_data;

  assign w_len      = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign w_in_fire  = (r_state == S_WDATA) && bus_gnt && in_valid;
  assign w_out_fire = r_out_valid && out_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;

  // State register
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; every bus-access state stalls while grant is withdrawn
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (w_len == 11'd0) ? S_DONE : S_REQ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ:     w_next = bus_gnt ? S_LATCH : S_REQ;
      S_LATCH:   w_next = bus_gnt ? S_ADDR_HI : S_LATCH;
      S_ADDR_HI: w_next = bus_gnt ? S_ADDR_LO : S_ADDR_HI;
      S_ADDR_LO: begin
        if (bus_gnt) begin
          w_next = r_read ? S_RISSUE : S_WDATA;
        end else begin
          w_next = S_ADDR_LO;
        end
      end
      S_WDATA: begin
        if (w_in_fire && (r_rem == 11'd1)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_WDATA;
        end
      end
      S_RISSUE: w_next = bus_gnt ? S_RCAPT : S_RISSUE;
      S_RCAPT:  w_next = S_RHOLD;
      S_RHOLD: begin
        if (w_out_fire) begin
          w_next = (r_rem == 11'd0) ? S_DONE : S_RISSUE;
        end else begin
          w_next = S_RHOLD;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command capture, byte counter and registered read-stream output
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= 14'h0000;
      r_rem       <= 11'd0;
      r_read      <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr <= cmd_addr;
            r_rem  <= w_len;
            r_read <= cmd_read;
          end
        end
        S_WDATA: begin
          if (w_in_fire && (r_rem != 11'd0)) begin
            r_rem <= r_rem - 11'd1;
          end
        end
        S_RCAPT: begin
          r_out_data  <= bus_din;
          r_out_valid <= 1'b1;
          if (r_rem != 11'd0) begin
            r_rem <= r_rem - 11'd1;
          end
        end
        S_RHOLD: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= r_out_valid;
        end
      endcase
    end
  end

  // Output decode: bus fields are forced idle whenever no access is issued
  always_comb begin
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    bus_req    = 1'b0;
    in_ready   = 1'b0;
    w_acc_en   = 1'b0;
    w_acc_rd   = 1'b1;
    w_acc_addr = 16'h0000;
    w_acc_data = 8'h00;
    case (r_state)
      S_REQ, S_RCAPT, S_RHOLD: begin
        bus_req = 1'b1;
      end
      S_LATCH: begin
        bus_req    = 1'b1;
        w_acc_en   = bus_gnt;
        w_acc_addr = STATUS_ADDR;
      end
      S_ADDR_HI: begin
        bus_req    = 1'b1;
        w_acc_en   = bus_gnt;
        w_acc_rd   = 1'b0;
        w_acc_addr = VADDR_ADDR;
        w_acc_data = {2'b00, r_addr[13:8]};
      end
      S_ADDR_LO: begin
        bus_req    = 1'b1;
        w_acc_en   = bus_gnt;
        w_acc_rd   = 1'b0;
        w_acc_addr = VADDR_ADDR;
        w_acc_data = r_addr[7:0];
      end
      S_WDATA: begin
        bus_req    = 1'b1;
        in_ready   = bus_gnt;
        w_acc_en   = bus_gnt && in_valid;
        w_acc_rd   = 1'b0;
        w_acc_addr = DATA_ADDR;
        w_acc_data = in_data;
      end
      S_RISSUE: begin
        bus_req    = 1'b1;
        w_acc_en   = bus_gnt;
        w_acc_addr = DATA_ADDR;
      end
      default: begin
        bus_req = 1'b0;
      end
    endcase
    if (w_acc_en) begin
      bus_en   = 1'b1;
      bus_addr = w_acc_addr;
      bus_wr   = w_acc_rd;
      bus_dout = w_acc_rd ? 8'h00 : w_acc_data;
    end else begin
      bus_en   = 1'b0;
      bus_addr = 16'h0000;
      bus_wr   = 1'b1;
      bus_dout = 8'h00;
    end
  end

endmodule

// File: tb/tb_ppu_loader.sv
// tb_ppu_loader: randomized bench for ppu_loader with a PPU register/VRAM model
// and a command-level reference of the expected bus sequence and VRAM contents.
module tb_ppu_loader;

  logic        cpu_clk   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        start     = 1'b0;
  logic [13:0] cmd_addr  = 14'h0000;
  logic [10:0] cmd_len   = 11'd0;
  logic        cmd_read  = 1'b0;
  logic        bus_gnt   = 1'b0;
  logic [7:0]  bus_din   = 8'h00;
  logic [7:0]  in_data   = 8'h00;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, bus_req, bus_en, bus_wr, in_ready, out_valid;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout, out_data;

  ppu_loader dut (
    .cpu_clk(cpu_clk), .reset_n(reset_n), .start(start), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_read(cmd_read), .busy(busy), .done(done),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_en(bus_en), .bus_addr(bus_addr),
    .bus_dout(bus_dout), .bus_wr(bus_wr), .bus_din(bus_din), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 cpu_clk = ~cpu_clk;

  int total = 0;
  int bad   = 0;

  // PPU model: address toggle, auto-incrementing VRAM pointer, read data next cycle
  logic [7:0]  vram [0:16383];
  logic [13:0] p_vaddr  = 14'h0000;
  logic        p_toggle = 1'b0;
  logic        dev_init = 1'b0;
  always @(posedge cpu_clk) begin
    if (!dev_init) begin
      for (int i = 0; i < 16384; i++) vram[i] <= 8'(i) ^ 8'h5A;
      dev_init <= 1'b1;
    end else if (bus_en) begin
      if (bus_addr == 16'h2002) begin
        p_toggle <= 1'b0;
      end else if (bus_addr == 16'h2006 && !bus_wr) begin
        if (!p_toggle) p_vaddr[13:8] <= bus_dout[5:0];
        else           p_vaddr[7:0]  <= bus_dout;
        p_toggle <= ~p_toggle;
      end else if (bus_addr == 16'h2007) begin
        if (!bus_wr) vram[p_vaddr] <= bus_dout;
        else         bus_din <= vram[p_vaddr];
        p_vaddr <= p_vaddr + 14'd1;
      end
    end
  end

  logic [7:0]  ref_vram [0:16383];
  logic [24:0] obs_bus[$];
  logic [24:0] exp_bus[$];
  int          obs_cyc[$];
  logic [7:0]  obs_out[$];
  logic [7:0]  wq[$];
  logic [7:0]  wdat[$];
  int   done_cyc, done_cnt, last_acc_cyc, last_hs_cyc, first_data_cyc, req_cnt, hold_reads;
  logic busy_after, hold_unstable, pre_en;

  task automatic build_exp(input logic [13:0] a, input int n, input logic rd);
    exp_bus.delete();
    exp_bus.push_back({1'b1, 16'h2002, 8'h00});
    exp_bus.push_back({1'b0, 16'h2006, {2'b00, a[13:8]}});
    exp_bus.push_back({1'b0, 16'h2006, a[7:0]});
    for (int i = 0; i < n; i++)
      exp_bus.push_back(rd ? {1'b1, 16'h2007, 8'h00} : {1'b0, 16'h2007, wdat[i]});
  endtask

  task automatic commit_writes(input logic [13:0] a, input int n);
    for (int i = 0; i < n; i++) ref_vram[a + 14'(i)] = wdat[i];
  endtask

  task automatic make_wdata(input int n);
    logic [7:0] b;
    wq.delete(); wdat.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      wq.push_back(b); wdat.push_back(b);
    end
  endtask

  function automatic int seq_errs();
    int e;
    e = (obs_bus.size() != exp_bus.size()) ? 1 : 0;
    for (int i = 0; i < obs_bus.size() && i < exp_bus.size(); i++)
      if (obs_bus[i] !== exp_bus[i]) e++;
    return e;
  endfunction

  function automatic int out_errs(input logic [13:0] a, input int n);
    int e;
    e = (obs_out.size() != n) ? 1 : 0;
    for (int i = 0; i < obs_out.size() && i < n; i++)
      if (obs_out[i] !== ref_vram[a + 14'(i)]) e++;
    return e;
  endfunction

  // Runs one command cycle by cycle (cycle 0 carries start) and records what happened.
  task automatic drive_cmd(input logic [13:0] a, input logic [10:0] len, input logic rd,
                           input int gap_s, input int gap_n, input int drop_pct,
                           input int valid_pct, input int ready_pct,
                           input int hold_idx, input int hold_n, input int abort_after);
    int cyc, fired, held;
    logic fire_in, in_hold;
    logic [7:0] held_data;
    obs_bus.delete(); obs_cyc.delete(); obs_out.delete();
    done_cyc = -1; done_cnt = 0; last_acc_cyc = -1; last_hs_cyc = -1;
    first_data_cyc = -1; req_cnt = 0; hold_reads = 0;
    busy_after = 1'b1; hold_unstable = 1'b0; pre_en = 1'b0;
    cyc = 0; fired = 0; held = 0; held_data = 8'h00;
    cmd_addr = a; cmd_len = len; cmd_read = rd; start = 1'b1;
    while (1) begin
      bus_gnt  = !(cyc >= gap_s && cyc < gap_s + gap_n) && (int'($urandom_range(99)) >= drop_pct);
      in_valid = (wq.size() > 0) && (int'($urandom_range(99)) < valid_pct);
      in_data  = (wq.size() > 0) ? wq[0] : 8'h00;
      in_hold  = out_valid && (obs_out.size() == hold_idx) && (held < hold_n);
      if (in_hold) begin
        if (held == 0) held_data = out_data;
        held++;
        out_ready = 1'b0;
      end else begin
        out_ready = int'($urandom_range(99)) < ready_pct;
      end
      if (abort_after >= 0 && fired == abort_after) begin
        #1;
        pre_en  = bus_en;
        reset_n = 1'b0;
        #1;
        return;
      end
      @(negedge cpu_clk);
      if (bus_en) begin
        obs_bus.push_back({bus_wr, bus_addr, bus_dout});
        obs_cyc.push_back(cyc);
        last_acc_cyc = cyc;
        if (bus_addr == 16'h2007 && first_data_cyc < 0) first_data_cyc = cyc;
        if (in_hold) hold_reads++;
      end
      if (in_hold && out_data !== held_data) hold_unstable = 1'b1;
      if (bus_req) req_cnt++;
      fire_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        obs_out.push_back(out_data);
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
      @(posedge cpu_clk);
      #1;
      start = 1'b0;
      if (fire_in) begin
        void'(wq.pop_front());
        fired++;
      end
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 1) break;
      if (cyc > 3000) break;
    end
    in_valid = 1'b0; out_ready = 1'b0; bus_gnt = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    total++;
    if ({busy, done, bus_req, bus_en, in_ready, out_valid} !== 6'b000000) begin
      bad++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, bus_req, bus_en, in_ready, out_valid});
    end
    total++;
    if (bus_wr !== 1'b1) begin bad++; $display("FAIL reset_bus_wr got %b want 1", bus_wr); end
    total++;
    if ({bus_addr, bus_dout, out_data} !== 32'h0) begin
      bad++; $display("FAIL reset_data got %h want 0", {bus_addr, bus_dout, out_data});
    end
    #1 reset_n = 1'b1;
    @(posedge cpu_clk); #1;
    bus_gnt = 1'b1; in_valid = 1'b1;
    @(negedge cpu_clk);
    total++;
    if ({in_ready, bus_req, bus_en} !== 3'b000) begin
      bad++; $display("FAIL idle_quiet got %b want 000", {in_ready, bus_req, bus_en});
    end
    @(posedge cpu_clk); #1;
    bus_gnt = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_write();
    wq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wdat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_exp(14'h2000, 4, 1'b0);
    drive_cmd(14'h2000, 11'd4, 1'b0, 0, 0, 0, 100, 100, -1, 0, -1);
    commit_writes(14'h2000, 4);
    total++; if (seq_errs() != 0) begin bad++; $display("FAIL write_seq got %0d bad accesses want 0", seq_errs()); end
    total++; if (first_data_cyc != 5) begin bad++; $display("FAIL write_first got %0d want 5", first_data_cyc); end
    total++; if (done_cyc != 9) begin bad++; $display("FAIL write_done got %0d want 9", done_cyc); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL write_done_cnt got %0d want 1", done_cnt); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL write_busy_after got %b want 0", busy_after); end
  endtask

  task automatic test_read();
    wq = '{8'h0F, 8'h30, 8'h21};
    wdat = '{8'h0F, 8'h30, 8'h21};
    drive_cmd(14'h3F00, 11'd3, 1'b0, 0, 0, 0, 100, 100, -1, 0, -1);
    commit_writes(14'h3F00, 3);
    build_exp(14'h3F00, 3, 1'b1);
    drive_cmd(14'h3F00, 11'd3, 1'b1, 0, 0, 0, 100, 100, -1, 0, -1);
    total++; if (seq_errs() != 0) begin bad++; $display("FAIL read_seq got %0d bad accesses want 0", seq_errs()); end
    total++;
    if ({obs_out[0], obs_out[1], obs_out[2]} !== 24'h0F3021 || obs_out.size() != 3) begin
      bad++; $display("FAIL read_stream got %h (n=%0d) want 0f3021", {obs_out[0], obs_out[1], obs_out[2]}, obs_out.size());
    end
    total++; if (last_hs_cyc != 13) begin bad++; $display("FAIL read_rate got %0d want 13", last_hs_cyc); end
    total++; if (done_cyc != last_hs_cyc + 1) begin bad++; $display("FAIL read_done got %0d want %0d", done_cyc, last_hs_cyc + 1); end
  endtask

  task automatic test_grant_loss();
    logic [13:0] a;
    int in_gap;
    a = 14'($urandom);
    make_wdata(6);
    build_exp(a, 6, 1'b0);
    drive_cmd(a, 11'd6, 1'b0, 4, 4, 0, 100, 100, -1, 0, -1);
    commit_writes(a, 6);
    in_gap = 0;
    foreach (obs_cyc[i]) if (obs_cyc[i] >= 4 && obs_cyc[i] < 8) in_gap++;
    total++; if (in_gap != 0) begin bad++; $display("FAIL gnt_gap_quiet got %0d accesses want 0", in_gap); end
    total++; if (seq_errs() != 0) begin bad++; $display("FAIL gnt_seq got %0d bad accesses want 0", seq_errs()); end
    total++; if (obs_cyc[2] != 8) begin bad++; $display("FAIL gnt_addr_lo got cycle %0d want 8", obs_cyc[2]); end
  endtask

  task automatic test_backpressure();
    logic [13:0] a;
    a = 14'($urandom);
    make_wdata(5);
    drive_cmd(a, 11'd5, 1'b0, 0, 0, 0, 100, 100, -1, 0, -1);
    commit_writes(a, 5);
    build_exp(a, 5, 1'b1);
    drive_cmd(a, 11'd5, 1'b1, 0, 0, 0, 100, 100, 1, 10, -1);
    total++; if (hold_reads != 0) begin bad++; $display("FAIL hold_reads got %0d want 0", hold_reads); end
    total++; if (hold_unstable !== 1'b0) begin bad++; $display("FAIL hold_stable got %b want 0", hold_unstable); end
    total++; if (out_errs(a, 5) != 0) begin bad++; $display("FAIL hold_stream got %0d bad bytes want 0", out_errs(a, 5)); end
    total++; if (last_hs_cyc != 29) begin bad++; $display("FAIL hold_timing got %0d want 29", last_hs_cyc); end
    total++; if (seq_errs() != 0) begin bad++; $display("FAIL hold_seq got %0d bad accesses want 0", seq_errs()); end
  endtask

  task automatic test_len_zero();
    drive_cmd(14'($urandom), 11'd0, 1'($urandom), 0, 0, 0, 100, 100, -1, 0, -1);
    total++; if (done_cyc != 1) begin bad++; $display("FAIL len0_done got %0d want 1", done_cyc); end
    total++; if (req_cnt != 0) begin bad++; $display("FAIL len0_req got %0d want 0", req_cnt); end
    total++; if (obs_bus.size() != 0) begin bad++; $display("FAIL len0_bus got %0d want 0", obs_bus.size()); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL len0_busy got %b want 0", busy_after); end
  endtask

  task automatic test_clamp();
    logic [13:0] a;
    a = 14'($urandom);
    make_wdata(1100);
    build_exp(a, 1024, 1'b0);
    drive_cmd(a, 11'd2047, 1'b0, 0, 0, 0, 100, 100, -1, 0, -1);
    commit_writes(a, 1024);
    total++; if (seq_errs() != 0) begin bad++; $display("FAIL clamp_seq got %0d accesses (%0d bad) want 1027", obs_bus.size(), seq_errs()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL clamp_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_abort();
    logic [13:0] a;
    a = 14'($urandom);
    make_wdata(256);
    drive_cmd(a, 11'd256, 1'b0, 0, 0, 0, 100, 100, -1, 0, 100);
    commit_writes(a, 100);
    total++; if (pre_en !== 1'b1) begin bad++; $display("FAIL abort_pre_en got %b want 1", pre_en); end
    total++;
    if ({bus_req, bus_en, busy, done, out_valid} !== 5'b00000) begin
      bad++; $display("FAIL abort_release got %b want 00000", {bus_req, bus_en, busy, done, out_valid});
    end
    in_valid = 1'b0; bus_gnt = 1'b0; start = 1'b0;
    @(posedge cpu_clk); #1 reset_n = 1'b1;
    @(posedge cpu_clk); #1;
    make_wdata(3);
    build_exp(a, 3, 1'b0);
    drive_cmd(a, 11'd3, 1'b0, 0, 0, 0, 100, 100, -1, 0, -1);
    commit_writes(a, 3);
    total++; if (seq_errs() != 0) begin bad++; $display("FAIL abort_restart got %0d bad accesses want 0", seq_errs()); end
  endtask

  task automatic test_random();
    logic [13:0] a;
    logic rd;
    int n;
    for (int it = 0; it < 10; it++) begin
      a  = 14'($urandom);
      n  = int'($urandom_range(24, 1));
      rd = 1'($urandom);
      if (rd) begin wq.delete(); wdat.delete(); end
      else make_wdata(n);
      build_exp(a, n, rd);
      drive_cmd(a, 11'(n), rd, 0, 0, 25, 70, 60, -1, 0, -1);
      total++; if (seq_errs() != 0) begin bad++; $display("FAIL rand_seq it=%0d got %0d bad accesses want 0", it, seq_errs()); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL rand_done it=%0d got %0d want 1", it, done_cnt); end
      total++; if (out_errs(a, rd ? n : 0) != 0) begin bad++; $display("FAIL rand_stream it=%0d got %0d bad bytes want 0", it, out_errs(a, rd ? n : 0)); end
      if (!rd) commit_writes(a, n);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ref_vram[i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_write();
    test_read();
    test_grant_loss();
    test_backpressure();
    test_len_zero();
    test_clamp();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
